serial_frame_capture: RTL and testbench

- Downstream stage of the serial pattern-detect FSM.
- Consumes the detector's one-cycle Moore output pulse (`start`), then shifts the next DATA_W bits in MSB-first from the same serial line `in`.
- Presents the captured word with a `valid`/`ack` handshake and holds it until the consumer acknowledges.
- Tracks overrun when a new start arrives while a word is still unacknowledged.

---
 rtl/serial_frame_capture.sv | 129 ++++++++++++
 tb/tb_serial_frame_capture.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/serial_frame_capture.sv
// Captures the DATA_W-bit payload that follows a pattern-detect pulse and holds it behind a valid/ack handshake.
// Optional trailing even-parity check is built when SERIAL_FRAME_PARITY_CHECK_EN is defined.
module serial_frame_capture #(
    parameter  int DATA_W = 4,
    localparam int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in,
    input  logic              start,
    input  logic              ack,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              busy,
    output logic              overrun,
    output logic              par_err
);

`ifdef SERIAL_FRAME_PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd3} state_t;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    function automatic logic odd_parity(input logic [DATA_W-1:0] word);
        return ^word;
    endfunction

    state_t              state_q;
    logic [DATA_W-1:0]   shreg_q;
    logic [DATA_W-1:0]   shreg_d;
    logic [CNT_W-1:0]    count_q;
    logic [DATA_W-1:0]   data_q;
    logic                valid_q;
    logic                busy_q;
    logic                overrun_q;
    logic                last_s;

    // Next shift-register value and detection of the final payload sample
    always_comb begin
        shreg_d = DATA_W'({shreg_q, in});
        last_s  = (count_q == LAST_CNT);
    end

`ifdef SERIAL_FRAME_PARITY_CHECK_EN
    logic par_err_q;
    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    // Frame capture FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            count_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_CHECK_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                // The start edge itself samples the MSB, so IDLE and SHIFT share the shift path.
                IDLE, SHIFT: begin
                    if ((state_q == SHIFT) || start) begin
                        shreg_q <= shreg_d;
                        count_q <= count_q + CNT_W'(1);
                        busy_q  <= 1'b1;
                        if (last_s) begin
`ifdef SERIAL_FRAME_PARITY_CHECK_EN
                            state_q <= PAR;
`else
                            state_q <= DONE;
                            data_q  <= shreg_d;
                            valid_q <= 1'b1;
`endif
                        end else begin
                            state_q <= SHIFT;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
`ifdef SERIAL_FRAME_PARITY_CHECK_EN
                PAR: begin
                    state_q   <= DONE;
                    data_q    <= shreg_q;
                    valid_q   <= 1'b1;
                    par_err_q <= odd_parity(shreg_q) ^ in;
                end
`endif
                DONE: begin
                    if (ack) begin
                        state_q   <= IDLE;
                        count_q   <= '0;
                        valid_q   <= 1'b0;
                        busy_q    <= 1'b0;
                        overrun_q <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_CHECK_EN
                        par_err_q <= 1'b0;
`endif
                    end else if (start) begin
                        overrun_q <= 1'b1;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= '0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out = data_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_serial_frame_capture.sv
// Scoreboard bench for serial_frame_capture: frames are issued with random payloads, holds, overruns and
// ack/start collisions; a monitor checks every captured word, its parity flag and its arrival cycle.
module tb_serial_frame_capture;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         din;
    logic         start;
    logic         ack;
    logic [W-1:0] data_out;
    logic         valid;
    logic         busy;
    logic         overrun;
    logic         par_err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [W-1:0] word;
        logic         perr;
        int           cyc;
    } exp_t;
    exp_t exp_q[$];

    serial_frame_capture #(.DATA_W(W)) dut (
        .clk(clk), .rst(rst), .in(din), .start(start), .ack(ack),
        .data_out(data_out), .valid(valid), .busy(busy), .overrun(overrun), .par_err(par_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: each rising valid must match the oldest expected frame; a held word must not change.
    logic         vprev = 1'b0;
    logic [W-1:0] held_word;
    logic         held_perr;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (valid && !vprev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("data_out", 32'(data_out), 32'(e.word));
                chk("par_err", 32'(par_err), 32'(e.perr));
                chk("valid_latency", 32'(cyc), 32'(e.cyc));
            end
        end else if (valid && vprev) begin
            chk("held_data", 32'(data_out), 32'(held_word));
            chk("held_par_err", 32'(par_err), 32'(held_perr));
        end
        vprev     <= valid;
        held_word <= data_out;
        held_perr <= par_err;
    end

    // One complete frame: payload MSB-first, optional parity bit, hold, optional overrun, then ack.
    task automatic send_frame(input logic [W-1:0] w, input logic pbit, input int hold,
                              input bit ovr, input bit collide);
        logic perr;
        @(negedge clk);
        start = 1'b1;
        din   = w[W-1];
        ack   = 1'b0;
        for (int i = W - 2; i >= 0; i--) begin
            @(negedge clk);
            if (i == W - 2) chk("busy_after_start", 32'(busy), 32'd1);
            start = 1'($urandom_range(0, 1));
            din   = w[i];
        end
`ifdef SERIAL_FRAME_PARITY_CHECK_EN
        @(negedge clk);
        start = 1'b0;
        din   = pbit;
        perr  = (^w) ^ pbit;
`else
        perr  = 1'b0;
`endif
        exp_q.push_back('{w, perr, cyc + 1});
        @(negedge clk);
        chk("valid_rise", 32'(valid), 32'd1);
        for (int k = 0; k < hold; k++) begin
            start = ovr && (k == 0);
            din   = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0;
        if (hold > 0) begin
            chk("overrun", 32'(overrun), 32'(ovr));
            chk("valid_hold", 32'(valid), 32'd1);
        end
        ack   = 1'b1;
        start = collide;
        @(negedge clk);
        ack   = 1'b0;
        start = 1'b0;
        chk("valid_after_ack", 32'(valid), 32'd0);
        chk("busy_after_ack", 32'(busy), 32'd0);
        chk("overrun_after_ack", 32'(overrun), 32'd0);
        chk("par_err_after_ack", 32'(par_err), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        din   = 1'b0;
        ack   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            din = ~din;
        end
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_par_err", 32'(par_err), 32'd0);
        rst   = 1'b0;
        start = 1'b0;

        // Reset in the middle of a frame discards it
        @(negedge clk); start = 1'b1; din = 1'b1;
        @(negedge clk); start = 1'b0; din = 1'b0;
        @(negedge clk); rst = 1'b1; din = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_data", 32'(data_out), 32'd0);
        repeat (W + 2) @(negedge clk);
        chk("midrst_no_valid", 32'(valid), 32'd0);

        send_frame(4'b1011, 1'b1, 2, 1'b0, 1'b0);
        send_frame(4'b1011, 1'b0, 1, 1'b0, 1'b0);
        send_frame(4'b0110, 1'b0, 5, 1'b1, 1'b0);
        send_frame(4'b1001, 1'b1, 0, 1'b0, 1'b1);
        send_frame(4'hF,    1'b0, 1, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int hold;
            hold = $urandom_range(0, 4);
            send_frame(W'($urandom), 1'($urandom_range(0, 1)), hold,
                       (hold > 0) && ($urandom_range(0, 1) == 1), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                din = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("idle_busy", 32'(busy), 32'd0);
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
